uart_rx_param: RTL and testbench

Parametrised UART receiver, the successor to the fixed 8N1 receiver in the UART-SPI bridge.
- Frame format is configurable: data bits, parity, stop bits.
- Input is synchronised, and each bit is decided by a 3-sample majority vote.
- Start bits are validated; framing, parity and overrun errors are reported.
- Bytes are delivered over a valid/ready handshake to the bridge command parser.

---
 rtl/uart_rx_param.sv | 250 +++++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with majority-vote sampling
//
// Optional feature macro: UART_RX_BREAK_DET_EN (break frames are swallowed,
// break_det pulses, and a new start is armed only after a full idle bit time).
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   rx         asynchronous serial line, idles high
//   data_out   received word, valid while data_valid=1
//   data_valid word available
//   data_ready consumer accepts the word
//   parity_err parity mismatch on held word (qualified by data_valid)
//   frame_err  stop bit sampled 0 on held word (qualified by data_valid)
//   overrun    one-cycle pulse when a completed frame is dropped
//   break_det  one-cycle pulse on a break frame (0 unless macro defined)
//   busy       receiver is inside a frame
module uart_rx_param #(
  parameter int CLK_PER_BIT = 87,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int H  = CLK_PER_BIT / 2;
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LOAD = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(H + 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(H);
  localparam logic [CW-1:0] CNT_DEC  = CW'(H - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_hi;
  logic [1:0]           fill;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic                 stop_idx;
  logic                 samp0;
  logic                 samp1;
  logic [DATA_BITS-1:0] data_shift;
  logic                 parity_bad;
  logic                 frame_bad;
  logic                 frame_done;
  logic                 vote;
  logic                 at_dec;
  logic                 at_end;
  logic                 start_edge;
  logic                 is_break;

`ifdef UART_RX_BREAK_DET_EN
  logic                 par_bit;
  logic                 break_wait;
  logic [CW-1:0]        hi_cnt;
`endif

  // Two-flop synchroniser. fill marks when rx_s carries the real line rather
  // than the reset value, so a line held low out of reset never looks like a
  // 1->0 transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      fill    <= 2'b00;
      rx_hi   <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      fill    <= {fill[0], 1'b1};
      rx_hi   <= fill[1] & rx_s;
    end
  end

  // Third sample is rx_s itself in the decision cycle.
  assign vote   = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
  assign at_dec = (cnt == CNT_DEC);
  assign at_end = (cnt == '0);
  assign busy   = (state != S_IDLE);

`ifdef UART_RX_BREAK_DET_EN
  assign start_edge = rx_hi & ~rx_s & ~break_wait;
  assign is_break   = frame_done & (data_shift == '0) & ~par_bit & frame_bad;
`else
  assign start_edge = rx_hi & ~rx_s;
  assign is_break   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      stop_idx   <= 1'b0;
      samp0      <= 1'b0;
      samp1      <= 1'b0;
      data_shift <= '0;
      parity_bad <= 1'b0;
      frame_bad  <= 1'b0;
      frame_done <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (state != S_IDLE) begin
        if (cnt == CNT_S0) samp0 <= rx_s;
        if (cnt == CNT_S1) samp1 <= rx_s;
        cnt <= at_end ? CNT_LOAD : cnt - 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            state      <= S_START;
            cnt        <= CNT_LOAD;
            parity_bad <= 1'b0;
            frame_bad  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            par_bit    <= 1'b0;
`endif
          end
        end
        S_START: begin
          if (at_dec && vote) begin
            state <= S_IDLE;
          end else if (at_end) begin
            state <= S_DATA;
            idx   <= '0;
          end
        end
        S_DATA: begin
          if (at_dec) data_shift[idx] <= vote;
          if (at_end) begin
            if (idx == IDX_LAST) begin
              state    <= (PARITY != 0) ? S_PARITY : S_STOP;
              stop_idx <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (at_dec) begin
            parity_bad <= (PARITY == 1) ? ~(^data_shift ^ vote) : (^data_shift ^ vote);
`ifdef UART_RX_BREAK_DET_EN
            par_bit    <= vote;
`endif
          end
          if (at_end) begin
            state    <= S_STOP;
            stop_idx <= 1'b0;
          end
        end
        S_STOP: begin
          // Leaving at the decision point of the last stop bit lets a
          // back-to-back start edge be caught half a bit early.
          if (at_dec) begin
            if (!vote) frame_bad <= 1'b1;
            if (stop_idx == STOP_LAST) begin
              state      <= S_IDLE;
              frame_done <= 1'b1;
            end
          end else if (at_end) begin
            stop_idx <= stop_idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output holding register and handshake. A consume in the completion cycle
  // makes room for the new word, so no overrun in that case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (frame_done && !is_break) begin
        if (!data_valid || data_ready) begin
          data_out   <= data_shift;
          parity_err <= parity_bad;
          frame_err  <= frame_bad;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  // After a break the line must stay high a full bit time before re-arming.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      break_det  <= 1'b0;
      break_wait <= 1'b0;
      hi_cnt     <= '0;
    end else begin
      break_det <= is_break;
      if (is_break) begin
        break_wait <= 1'b1;
        hi_cnt     <= '0;
      end else if (break_wait) begin
        if (!rx_s) begin
          hi_cnt <= '0;
        end else if (hi_cnt == CNT_LOAD) begin
          break_wait <= 1'b0;
          hi_cnt     <= '0;
        end else begin
          hi_cnt <= hi_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign break_det = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - self-checking bench for uart_rx_param (8N1 and 8E2 instances)
module tb_uart_rx_param;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_a = 1'b0;
  logic       rx_b = 1'b1;
  logic       rdy_a = 1'b1;
  logic       rdy_b = 1'b1;
  logic [7:0] dout_a, dout_b;
  logic       dv_a, dv_b, perr_a, perr_b, ferr_a, ferr_b;
  logic       ovr_a, ovr_b, brk_a, brk_b, busy_a, busy_b;

  int checks = 0;
  int errors = 0;
  int ovr_cnt_a = 0;
  int brk_cnt = 0;
  logic [9:0] q_a[$];
  logic [9:0] q_b[$];

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(rst), .rx(rx_a), .data_out(dout_a), .data_valid(dv_a),
    .data_ready(rdy_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a),
    .break_det(brk_a), .busy(busy_a)
  );

  uart_rx_param #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_b (
    .clk(clk), .rst(rst), .rx(rx_b), .data_out(dout_b), .data_valid(dv_b),
    .data_ready(rdy_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b),
    .break_det(brk_b), .busy(busy_b)
  );

  // Scoreboard capture of every completed transfer and pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (dv_a && rdy_a) q_a.push_back({perr_a, ferr_a, dout_a});
      if (dv_b && rdy_b) q_b.push_back({perr_b, ferr_b, dout_b});
      if (ovr_a) ovr_cnt_a <= ovr_cnt_a + 1;
      if (brk_a || brk_b) brk_cnt <= brk_cnt + 1;
    end
  end

  typedef struct {
    bit         sel_b;
    logic [7:0] d;
    logic       pb;
    logic       s1;
    logic       s2;
    int         gbit;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_line(input bit sel_b, input logic v);
    if (sel_b) rx_b = v;
    else rx_a = v;
  endtask

  task automatic drive_bit(input bit sel_b, input logic v, input bit glitch);
    for (int j = 0; j < CPB; j++) begin
      @(posedge clk);
      #1;
      set_line(sel_b, (glitch && j == 8) ? ~v : v);
    end
  endtask

  task automatic send_frame(input bit sel_b, input logic [7:0] d, input logic pb,
                            input logic s1, input logic s2, input int gbit, input int idle);
    drive_bit(sel_b, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel_b, d[i], gbit == i);
    if (sel_b) drive_bit(sel_b, pb, 1'b0);
    drive_bit(sel_b, s1, 1'b0);
    if (sel_b) drive_bit(sel_b, s2, 1'b0);
    for (int i = 0; i < idle; i++) begin
      @(posedge clk);
      #1;
      set_line(sel_b, 1'b1);
    end
  endtask

  initial begin
    int n0;
    int base;
    int done_cyc;
    bit saw;
    logic [9:0] last;

    //            sel  d      pb    s1    s2    gbit exp_d  pe    fe
    vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, -1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, -1, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b1,  3, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h5A, 1'b0, 1'b1, 1'b1, -1, 8'h5A, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b1, -1, 8'h03, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, -1, 8'h03, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, -1, 8'h5A, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, -1, 8'h5A, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 8'h80, 1'b0, 1'b1, 1'b1, -1, 8'h80, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, -1, 8'h00, 1'b0, 1'b1};

    // Reset state, with line A held low through and after reset.
    repeat (3) @(negedge clk);
    check("reset_a", {dv_a, dout_a, perr_a, ferr_a, ovr_a, brk_a, busy_a}, 32'h0);
    check("reset_b", {dv_b, dout_b, perr_b, ferr_b, ovr_b, brk_b, busy_b}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    check("low_out_of_reset_busy", busy_a, 1'b0);
    check("low_out_of_reset_dv", dv_a, 1'b0);
    @(posedge clk);
    #1 rx_a = 1'b1;
    repeat (20) @(posedge clk);

    // Table-driven frames, consumer always ready.
    for (int i = 0; i < 10; i++) begin
      n0 = vecs[i].sel_b ? q_b.size() : q_a.size();
      send_frame(vecs[i].sel_b, vecs[i].d, vecs[i].pb, vecs[i].s1, vecs[i].s2, vecs[i].gbit, 8);
      if (vecs[i].sel_b) begin
        check($sformatf("vec%0d_count", i), q_b.size() - n0, 1);
        last = (q_b.size() > 0) ? q_b[q_b.size() - 1] : 10'h3FF;
      end else begin
        check($sformatf("vec%0d_count", i), q_a.size() - n0, 1);
        last = (q_a.size() > 0) ? q_a[q_a.size() - 1] : 10'h3FF;
      end
      check($sformatf("vec%0d_word", i), last, {vecs[i].exp_pe, vecs[i].exp_fe, vecs[i].exp_d});
    end

    // False start: 4-cycle low pulse.
    n0 = q_a.size();
    saw = 1'b0;
    done_cyc = -1;
    @(posedge clk);
    #1 rx_a = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) rx_a = 1'b1;
      @(negedge clk);
      if (busy_a) saw = 1'b1;
      if (saw && !busy_a && done_cyc < 0) done_cyc = k + 1;
    end
    check("false_start_busy_seen", saw, 1'b1);
    check("false_start_busy_clear", (done_cyc > 0 && done_cyc <= 16), 1'b1);
    repeat (20) @(posedge clk);
    check("false_start_no_data", q_a.size() - n0, 0);

    // Overrun: two back-to-back frames with consumer stalled.
    @(posedge clk);
    #1 rdy_a = 1'b0;
    base = ovr_cnt_a;
    send_frame(1'b0, 8'h11, 1'b0, 1'b1, 1'b1, -1, 0);
    send_frame(1'b0, 8'h22, 1'b0, 1'b1, 1'b1, -1, 8);
    @(negedge clk);
    check("overrun_dv_held", dv_a, 1'b1);
    check("overrun_data_held", dout_a, 8'h11);
    check("overrun_pulses", ovr_cnt_a - base, 1);
    n0 = q_a.size();
    @(posedge clk);
    #1 rdy_a = 1'b1;
    repeat (3) @(negedge clk);
    check("overrun_dv_drop", dv_a, 1'b0);
    check("overrun_consumed_count", q_a.size() - n0, 1);
    last = (q_a.size() > 0) ? q_a[q_a.size() - 1] : 10'h3FF;
    check("overrun_consumed_word", last, {2'b00, 8'h11});

    // Reset mid-frame while a word is held.
    @(posedge clk);
    #1 rdy_a = 1'b0;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, -1, 4);
    check("pre_reset_held", {dv_a, dout_a}, {1'b1, 8'h3C});
    n0 = q_a.size();
    fork
      send_frame(1'b0, 8'h0F, 1'b0, 1'b1, 1'b1, -1, 8);
      begin
        repeat (90) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midframe_reset_outputs", {dv_a, dout_a, perr_a, ferr_a, ovr_a, brk_a, busy_a}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    @(posedge clk);
    #1 rdy_a = 1'b1;
    repeat (4) @(negedge clk);
    check("midframe_reset_no_delivery", {24'h0, dv_a, 7'(q_a.size() - n0)}, 32'h0);

    // Recovery frame.
    n0 = q_a.size();
    send_frame(1'b0, 8'h7E, 1'b0, 1'b1, 1'b1, -1, 8);
    check("recover_count", q_a.size() - n0, 1);
    last = (q_a.size() > 0) ? q_a[q_a.size() - 1] : 10'h3FF;
    check("recover_word", last, {2'b00, 8'h7E});

    check("break_det_quiet", brk_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
